// File: rtl/aukv_wb_stage.sv
// Auk-V writeback stage: registers the retiring instruction, extracts load
// data, selects the writeback value, drives the register file write port and
// the forwarding bus, and maintains the retired-instruction counter.
module aukv_wb_stage #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_rd_we,
  input  logic [4:0]       i_rd_addr,
  input  logic [1:0]       i_wb_sel,
  input  logic [31:0]      i_alu_result,
  input  logic [31:0]      i_pc4,
  input  logic [31:0]      i_load_data,
  input  logic [2:0]       i_load_funct3,
  output logic             o_rf_we,
  output logic [4:0]       o_rf_addr,
  output logic [31:0]      o_rf_data,
  output logic             o_fwd_valid,
  output logic [4:0]       o_fwd_addr,
  output logic [31:0]      o_fwd_data,
  output logic [CNT_W-1:0] o_instret
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic             cap;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_ext;
  logic             we_d, we_q;
  logic [4:0]       addr_d, addr_q;
  logic [31:0]      data_d, data_q;
  logic [CNT_W-1:0] instret_q;

  // Flush beats stall; a stalled instruction is re-presented, so it is taken
  // only once, on the cycle the stall drops.
  assign cap = i_valid & ~i_stall & ~i_flush;

  // Select the addressed byte and halfword out of the aligned load word.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    load_byte = i_load_data[7:0];
    unique case (i_alu_result[1:0])
      2'd0: load_byte = i_load_data[7:0];
      2'd1: load_byte = i_load_data[15:8];
      2'd2: load_byte = i_load_data[23:16];
      2'd3: load_byte = i_load_data[31:24];
    endcase
    load_half = i_alu_result[1] ? i_load_data[31:16] : i_load_data[15:0];
  end

  // Sign/zero-extend per funct3; undefined encodings pass the raw word.
  always_comb begin
    load_ext = i_load_data;
    case (i_load_funct3)
      F3_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
      F3_LBU:  load_ext = {24'h0, load_byte};
      F3_LH:   load_ext = {{16{load_half[15]}}, load_half};
      F3_LHU:  load_ext = {16'h0, load_half};
      F3_LW:   load_ext = i_load_data;
      default: load_ext = i_load_data;
    endcase
  end

  // Writeback value mux and write qualification (reserved select and x0 never write).
  always_comb begin
    data_d = i_alu_result;
    case (i_wb_sel)
      WB_ALU:  data_d = i_alu_result;
      WB_LOAD: data_d = load_ext;
      WB_PC4:  data_d = i_pc4;
      WB_RSVD: data_d = i_alu_result;
    endcase
    addr_d = i_rd_addr;
    we_d   = i_rd_we & (i_wb_sel != WB_RSVD) & (i_rd_addr != 5'd0);
  end

  // WB pipeline register: capture on cap, otherwise a bubble that holds addr/data.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      we_q   <= 1'b0;
      addr_q <= 5'd0;
      data_q <= 32'h0;
    end else if (cap) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end else begin
      we_q   <= 1'b0;
    end
  end

  // Retired-instruction counter; counts every capture and wraps naturally.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      instret_q <= '0;
    end else if (cap) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign o_rf_we     = we_q;
  assign o_rf_addr   = addr_q;
  assign o_rf_data   = data_q;
  assign o_fwd_valid = we_q;
  assign o_fwd_addr  = addr_q;
  assign o_fwd_data  = data_q;
  assign o_instret   = instret_q;

endmodule

// File: tb/tb_aukv_wb_stage.sv
// Directed testbench for aukv_wb_stage: a 64-bit-counter instance checks the
// datapath, and a 4-bit-counter instance sharing the same stimulus checks wrap.
module tb_aukv_wb_stage;

  logic        i_clk;
  logic        i_rstn;
  logic        i_valid, i_stall, i_flush, i_rd_we;
  logic [4:0]  i_rd_addr;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_result, i_pc4, i_load_data;
  logic [2:0]  i_load_funct3;

  logic        o_rf_we, o_fwd_valid;
  logic [4:0]  o_rf_addr, o_fwd_addr;
  logic [31:0] o_rf_data, o_fwd_data;
  logic [63:0] o_instret;

  logic        s_rf_we, s_fwd_valid;
  logic [4:0]  s_rf_addr, s_fwd_addr;
  logic [31:0] s_rf_data, s_fwd_data;
  logic [3:0]  s_instret;

  int tests;
  int fails;
  logic [63:0] exp_cnt;

  aukv_wb_stage #(.CNT_W(64)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_rd_we(i_rd_we), .i_rd_addr(i_rd_addr),
    .i_wb_sel(i_wb_sel), .i_alu_result(i_alu_result), .i_pc4(i_pc4),
    .i_load_data(i_load_data), .i_load_funct3(i_load_funct3),
    .o_rf_we(o_rf_we), .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data),
    .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr),
    .o_fwd_data(o_fwd_data), .o_instret(o_instret)
  );

  aukv_wb_stage #(.CNT_W(4)) dut_small (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_rd_we(i_rd_we), .i_rd_addr(i_rd_addr),
    .i_wb_sel(i_wb_sel), .i_alu_result(i_alu_result), .i_pc4(i_pc4),
    .i_load_data(i_load_data), .i_load_funct3(i_load_funct3),
    .o_rf_we(s_rf_we), .o_rf_addr(s_rf_addr), .o_rf_data(s_rf_data),
    .o_fwd_valid(s_fwd_valid), .o_fwd_addr(s_fwd_addr),
    .o_fwd_data(s_fwd_data), .o_instret(s_instret)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write port and forwarding bus must agree with the expected values.
  task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] data, input bit chk_addr);
    check({tag, ".we"}, 64'(o_rf_we), 64'(we));
    check({tag, ".fwd_valid"}, 64'(o_fwd_valid), 64'(we));
    if (chk_addr) begin
      check({tag, ".addr"}, 64'(o_rf_addr), 64'(addr));
      check({tag, ".fwd_addr"}, 64'(o_fwd_addr), 64'(addr));
      check({tag, ".data"}, 64'(o_rf_data), 64'(data));
      check({tag, ".fwd_data"}, 64'(o_fwd_data), 64'(data));
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, ".instret"}, o_instret, exp_cnt);
    check({tag, ".instret4"}, 64'(s_instret), exp_cnt & 64'hF);
  endtask

  task automatic drive(input logic valid, input logic stall, input logic flush,
                       input logic rd_we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] ld, input logic [2:0] f3);
    i_valid = valid; i_stall = stall; i_flush = flush; i_rd_we = rd_we;
    i_rd_addr = rd; i_wb_sel = sel; i_alu_result = alu; i_pc4 = pc4;
    i_load_data = ld; i_load_funct3 = f3;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_cnt = 64'd0;
    i_rstn = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);

    // Reset state
    #12;
    check_wb("reset", 1'b0, 5'd0, 32'h0, 1'b1);
    check_cnt("reset");
    i_rstn = 1'b1;

    // ALU writeback
    drive(1, 0, 0, 1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 3'b000);
    step(); exp_cnt = 1;
    check_wb("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b1);
    check_cnt("alu");

    // Load lanes
    drive(1, 0, 0, 1, 5'd3, 2'b01, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 3'b000);
    step(); exp_cnt = 2;
    check_wb("lb_lane3", 1'b1, 5'd3, 32'hFFFF_FF80, 1'b1);
    drive(1, 0, 0, 1, 5'd3, 2'b01, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 3'b100);
    step(); exp_cnt = 3;
    check_wb("lbu_lane3", 1'b1, 5'd3, 32'h0000_0080, 1'b1);
    drive(1, 0, 0, 1, 5'd3, 2'b01, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 3'b001);
    step(); exp_cnt = 4;
    check_wb("lh_addr2", 1'b1, 5'd3, 32'hFFFF_80FF, 1'b1);
    drive(1, 0, 0, 1, 5'd3, 2'b01, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 3'b101);
    step(); exp_cnt = 5;
    check_wb("lhu_addr0", 1'b1, 5'd3, 32'h0000_7F01, 1'b1);
    drive(1, 0, 0, 1, 5'd3, 2'b01, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 3'b001);
    step(); exp_cnt = 6;
    check_wb("lh_addr1_ignores_bit0", 1'b1, 5'd3, 32'h0000_7F01, 1'b1);
    drive(1, 0, 0, 1, 5'd4, 2'b01, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 3'b010);
    step(); exp_cnt = 7;
    check_wb("lw", 1'b1, 5'd4, 32'h80FF_7F01, 1'b1);
    drive(1, 0, 0, 1, 5'd4, 2'b01, 32'h0000_1001, 32'h0, 32'hDEAD_BEEF, 3'b110);
    step(); exp_cnt = 8;
    check_wb("f3_110_raw", 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1);
    check_cnt("loads");

    // JAL and x0
    drive(1, 0, 0, 1, 5'd1, 2'b10, 32'h0, 32'h0000_0104, 32'h0, 3'b000);
    step(); exp_cnt = 9;
    check_wb("jal_rd1", 1'b1, 5'd1, 32'h0000_0104, 1'b1);
    drive(1, 0, 0, 1, 5'd0, 2'b10, 32'h0, 32'h0000_0104, 32'h0, 3'b000);
    step(); exp_cnt = 10;
    check_wb("jal_rd0", 1'b0, 5'd0, 32'h0, 1'b0);
    check_cnt("jal_rd0");

    // Stall for 3 cycles then release: one write pulse, one increment
    drive(1, 1, 0, 1, 5'd7, 2'b00, 32'h0000_AAAA, 32'h0, 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_wb("stall", 1'b0, 5'd0, 32'h0, 1'b0);
      check_cnt("stall");
    end
    i_stall = 1'b0;
    step(); exp_cnt = 11;
    check_wb("stall_release", 1'b1, 5'd7, 32'h0000_AAAA, 1'b1);
    check_cnt("stall_release");
    i_valid = 1'b0;
    step();
    check_wb("idle_holds", 1'b0, 5'd7, 32'h0000_AAAA, 1'b1);
    check_cnt("idle");

    // Flush, flush+stall, flush without valid
    drive(1, 0, 1, 1, 5'd8, 2'b00, 32'h0000_BBBB, 32'h0, 32'h0, 3'b000);
    step();
    check_wb("flush", 1'b0, 5'd7, 32'h0000_AAAA, 1'b1);
    check_cnt("flush");
    i_stall = 1'b1;
    step();
    check_wb("flush_stall", 1'b0, 5'd7, 32'h0000_AAAA, 1'b1);
    check_cnt("flush_stall");
    i_stall = 1'b0; i_valid = 1'b0;
    step();
    check_wb("flush_novalid", 1'b0, 5'd7, 32'h0000_AAAA, 1'b1);
    check_cnt("flush_novalid");

    // Reserved select: retires without writing
    drive(1, 0, 0, 1, 5'd9, 2'b11, 32'h0000_CCCC, 32'h0, 32'h0, 3'b000);
    step(); exp_cnt = 12;
    check_wb("wbsel_rsvd", 1'b0, 5'd0, 32'h0, 1'b0);
    check_cnt("wbsel_rsvd");

    // Reset mid-stream while a write is pending
    drive(1, 0, 0, 1, 5'd10, 2'b00, 32'h0000_0055, 32'h0, 32'h0, 3'b000);
    step(); exp_cnt = 13;
    check_wb("pre_reset", 1'b1, 5'd10, 32'h0000_0055, 1'b1);
    check_cnt("pre_reset");
    i_valid = 1'b0;
    i_rstn = 1'b0;
    #1; exp_cnt = 0;
    check_wb("async_reset", 1'b0, 5'd0, 32'h0, 1'b1);
    check_cnt("async_reset");
    step();
    i_rstn = 1'b1;
    drive(1, 0, 0, 1, 5'd11, 2'b00, 32'h0000_0077, 32'h0, 32'h0, 3'b000);
    step(); exp_cnt = 1;
    check_wb("post_reset", 1'b1, 5'd11, 32'h0000_0077, 1'b1);
    check_cnt("post_reset");

    // Counter wrap: 17 retirements since reset, 4-bit counter reads 1
    drive(1, 0, 0, 0, 5'd12, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);
    for (int i = 0; i < 16; i++) begin
      step();
      exp_cnt = exp_cnt + 64'd1;
    end
    check("wrap.instret4", 64'(s_instret), 64'd1);
    check("wrap.instret", o_instret, 64'd17);
    check_wb("wrap_nowrite", 1'b0, 5'd0, 32'h0, 1'b0);
    i_valid = 1'b0;
    step();
    check_cnt("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
